// File: rtl/bbj_mac_pkg.sv
// Shared constants, control payload and saturation bounds for the bbj_mac_pipe MAC.
package bbj_mac_pkg;

    localparam int unsigned A_W_DEF       = 24;
    localparam int unsigned B_W_DEF       = 16;
    localparam int unsigned ACC_W_DEF     = 48;
    localparam int unsigned NUM_STAGE_DEF = 3;
    localparam int unsigned NUM_STAGE_MIN = 2;
    localparam int unsigned NUM_STAGE_MAX = 6;
    localparam int unsigned SAT_MAX_W     = 128;

    // Per-beat control that travels alongside the multiplier pipeline.
    typedef struct packed {
        logic sgn;
        logic first;
        logic last;
    } mac_ctrl_t;

    // Largest representable value of a w-bit accumulator (w <= SAT_MAX_W).
    function automatic logic [SAT_MAX_W-1:0] sat_hi(input int unsigned w, input logic sgn);
        if (sgn) begin
            return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
        end
        return (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
    endfunction

    // Smallest representable value of a w-bit accumulator, as a bit pattern.
    function automatic logic [SAT_MAX_W-1:0] sat_lo(input int unsigned w, input logic sgn);
        if (sgn) begin
            return SAT_MAX_W'(1) << (w - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/bbj_mac_mul_pipe.sv
// NUM_STAGE-deep multiplier: operand register, product register, then delay stages.
module bbj_mac_mul_pipe
    import bbj_mac_pkg::*;
#(
    parameter int unsigned A_W       = A_W_DEF,
    parameter int unsigned B_W       = B_W_DEF,
    parameter int unsigned NUM_STAGE = NUM_STAGE_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce_i,
    input  logic                 valid_i,
    input  logic [A_W-1:0]       a_i,
    input  logic [B_W-1:0]       b_i,
    input  logic                 sgn_i,
    output logic [A_W+B_W-1:0]   prod_o,
    output logic                 valid_o
);

    localparam int unsigned P_W = A_W + B_W;

    logic [A_W-1:0]       a_q;
    logic [B_W-1:0]       b_q;
    logic                 sgn_q;
    logic [NUM_STAGE-1:0] vld_q;
    logic [P_W-1:0]       p_q [NUM_STAGE-1];
    logic [P_W-1:0]       a_ext_c;
    logic [P_W-1:0]       b_ext_c;
    logic [P_W-1:0]       mul_c;

    // A P_W-bit product of P_W-extended operands is exact for both signed and unsigned.
    assign a_ext_c = sgn_q ? P_W'($signed(a_q)) : P_W'(a_q);
    assign b_ext_c = sgn_q ? P_W'($signed(b_q)) : P_W'(b_q);
    assign mul_c   = a_ext_c * b_ext_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            sgn_q <= 1'b0;
        end else if (ce_i) begin
            vld_q <= {vld_q[NUM_STAGE-2:0], valid_i};
            sgn_q <= sgn_i;
        end
    end

    always_ff @(posedge clk) begin
        if (ce_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            p_q[0] <= mul_c;
            for (int unsigned k = 1; k < NUM_STAGE - 1; k++) begin
                p_q[k] <= p_q[k-1];
            end
        end
    end

    assign prod_o  = p_q[NUM_STAGE-2];
    assign valid_o = vld_q[NUM_STAGE-1];

endmodule

// File: rtl/bbj_mac_pipe.sv
// Pipelined multiply-accumulate with first/last grouping.
// Define BBJ_MAC_SAT_EN for saturating accumulation with a sticky per-group ovf flag.
module bbj_mac_pipe
    import bbj_mac_pkg::*;
#(
    parameter int unsigned A_W       = A_W_DEF,
    parameter int unsigned B_W       = B_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned NUM_STAGE = NUM_STAGE_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    input  logic             sgn,
    input  logic             first,
    input  logic             last,
    output logic [ACC_W-1:0] dout,
    output logic             out_valid,
    output logic             ovf
);

    localparam int unsigned P_W = A_W + B_W;

    logic [P_W-1:0]   prod;
    logic             prod_valid;
    mac_ctrl_t        ctrl_q [NUM_STAGE];
    mac_ctrl_t        arr_ctrl;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] base_c;
    logic [ACC_W-1:0] acc_nxt_c;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] dout_q, dout_d;
    logic             out_valid_q, out_valid_d;

    bbj_mac_mul_pipe #(
        .A_W       (A_W),
        .B_W       (B_W),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .ce_i    (ce),
        .valid_i (in_valid),
        .a_i     (din0),
        .b_i     (din1),
        .sgn_i   (sgn),
        .prod_o  (prod),
        .valid_o (prod_valid)
    );

    // Control delay line, aligned with the product leaving the multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NUM_STAGE; k++) begin
                ctrl_q[k] <= '0;
            end
        end else if (ce) begin
            ctrl_q[0] <= '{sgn: sgn, first: first, last: last};
            for (int unsigned k = 1; k < NUM_STAGE; k++) begin
                ctrl_q[k] <= ctrl_q[k-1];
            end
        end
    end

    assign arr_ctrl = ctrl_q[NUM_STAGE-1];
    assign p_ext    = arr_ctrl.sgn ? ACC_W'($signed(prod)) : ACC_W'(prod);
    assign base_c   = arr_ctrl.first ? '0 : acc_q;

`ifdef BBJ_MAC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_HI_S = ACC_W'(sat_hi(ACC_W, 1'b1));
    localparam logic [ACC_W-1:0] SAT_LO_S = ACC_W'(sat_lo(ACC_W, 1'b1));
    localparam logic [ACC_W-1:0] SAT_HI_U = ACC_W'(sat_hi(ACC_W, 1'b0));

    logic [ACC_W:0] sum_c;
    logic           sum_ovf_c;
    logic           grp_ovf_nxt_c;
    logic           grp_ovf_q, grp_ovf_d;
    logic           ovf_q, ovf_d;

    // One guard bit catches signed overflow and unsigned carry-out alike.
    always_comb begin
        sum_c = arr_ctrl.sgn ? ({base_c[ACC_W-1], base_c} + {p_ext[ACC_W-1], p_ext})
                             : ({1'b0, base_c} + {1'b0, p_ext});
        sum_ovf_c = arr_ctrl.sgn ? (sum_c[ACC_W] ^ sum_c[ACC_W-1]) : sum_c[ACC_W];
        acc_nxt_c = sum_c[ACC_W-1:0];
        if (sum_ovf_c) begin
            acc_nxt_c = !arr_ctrl.sgn ? SAT_HI_U : (sum_c[ACC_W] ? SAT_LO_S : SAT_HI_S);
        end
    end

    assign grp_ovf_nxt_c = sum_ovf_c | (grp_ovf_q & ~arr_ctrl.first);

    always_comb begin
        grp_ovf_d = grp_ovf_q;
        ovf_d     = ovf_q;
        if (prod_valid) begin
            grp_ovf_d = grp_ovf_nxt_c;
            if (arr_ctrl.last) begin
                ovf_d = grp_ovf_nxt_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grp_ovf_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (ce) begin
            grp_ovf_q <= grp_ovf_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign acc_nxt_c = base_c + p_ext;
    assign ovf       = 1'b0;
`endif

    always_comb begin
        acc_d       = acc_q;
        dout_d      = dout_q;
        out_valid_d = 1'b0;
        if (prod_valid) begin
            acc_d = acc_nxt_c;
            if (arr_ctrl.last) begin
                dout_d      = acc_nxt_c;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (ce) begin
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bbj_mac_pipe.sv
// Self-checking bench for bbj_mac_pipe: transaction-level MAC model plus directed literal cases.
module tb_bbj_mac_pipe;

    localparam int unsigned A_W = 24;
    localparam int unsigned B_W = 16;
    localparam int unsigned ACC_W = 48;
    localparam int unsigned NS = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b0, in_valid = 1'b0, sgn = 1'b0, first = 1'b0, last = 1'b0;
    logic [A_W-1:0] din0 = '0;
    logic [B_W-1:0] din1 = '0;
    logic [ACC_W-1:0] dout;
    logic out_valid, ovf;
    logic [39:0] dout40;
    logic out_valid40, ovf40;

    always #5 clk = ~clk;

    bbj_mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .NUM_STAGE(NS)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .sgn(sgn), .first(first), .last(last),
        .dout(dout), .out_valid(out_valid), .ovf(ovf));

    bbj_mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(40), .NUM_STAGE(NS)) dut40 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .sgn(sgn), .first(first), .last(last),
        .dout(dout40), .out_valid(out_valid40), .ovf(ovf40));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int unsigned due; logic [ACC_W-1:0] d; bit o; } exp_t;
    exp_t q[$];
    logic [127:0] m_acc = '0;
    bit m_govf = 1'b0;
    int unsigned ce_edges = 0;
    logic [ACC_W-1:0] last_d = '0;
    bit last_o = 1'b0;

    function automatic void model_beat(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                       input bit s, input bit f, input bit l);
        logic signed [127:0] av, bv, pv, base, sum, hi, lo, mask;
        bit o;
        o = 1'b0;
        av = s ? 128'($signed(a)) : 128'(a);
        bv = s ? 128'($signed(b)) : 128'(b);
        pv = av * bv;
        mask = (128'(1) << ACC_W) - 128'(1);
        if (f) base = 0;
        else if (s && m_acc[ACC_W-1]) base = m_acc | ~mask;
        else base = m_acc;
        sum = base + pv;
        hi = s ? ((128'(1) << (ACC_W - 1)) - 128'(1)) : mask;
        lo = s ? (-hi - 1) : 0;
`ifdef BBJ_MAC_SAT_EN
        if (sum > hi) begin sum = hi; o = 1'b1; end
        else if (sum < lo) begin sum = lo; o = 1'b1; end
`else
        if (sum > hi || sum < lo) o = 1'b0;
`endif
        m_acc = sum & mask;
        m_govf = (f ? 1'b0 : m_govf) | o;
        if (l) q.push_back('{due: ce_edges + NS, d: m_acc[ACC_W-1:0], o: m_govf});
    endfunction

    // Accepted beats are applied to the model at the clock edge that takes them.
    always @(posedge clk) begin
        if (reset_n && ce) begin
            ce_edges++;
            while (q.size() > 0 && q[0].due < ce_edges) void'(q.pop_front());
            if (in_valid) model_beat(din0, din1, sgn, first, last);
        end
    end

    // Compare outputs against the model every cycle.
    always @(negedge clk) begin
        bit exp_v;
        if (!reset_n) begin
            q.delete();
            m_acc = '0;
            m_govf = 1'b0;
            last_d = '0;
            last_o = 1'b0;
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_dout", 64'(dout), 64'(0));
            chk("rst_ovf", 64'(ovf), 64'(0));
        end else begin
            exp_v = (q.size() > 0) && (q[0].due == ce_edges);
            if (exp_v) begin
                last_d = q[0].d;
                last_o = q[0].o;
            end
            chk("out_valid", 64'(out_valid), 64'(exp_v));
            chk("dout", 64'(dout), 64'(last_d));
            chk("ovf", 64'(ovf), 64'(last_o));
        end
    end

    // Result collector for directed literal checks.
    typedef struct { int unsigned n; logic [ACC_W-1:0] d; bit o; } obs_t;
    obs_t obs[$];
    bit collect = 1'b0;
    int unsigned ncyc = 0;
    int cnt40 = 0;
    logic [39:0] d40 = '0;
    bit o40 = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (collect) begin
            if (out_valid) obs.push_back('{n: ncyc, d: dout, o: ovf});
            if (out_valid40) begin cnt40++; d40 = dout40; o40 = ovf40; end
        end
    end

    task automatic drive(input bit c, input bit v, input logic [A_W-1:0] a,
                         input logic [B_W-1:0] b, input bit s, input bit f, input bit l);
        @(posedge clk); #2;
        ce = c; in_valid = v; din0 = a; din1 = b; sgn = s; first = f; last = l;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset_n = 1'b0; in_valid = 1'b0; ce = 1'b1;
        #1;
        chk("rst_async_dout", 64'(dout), 64'(0));
        chk("rst_async_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
    endtask

    task automatic start_collect();
        obs.delete(); cnt40 = 0; collect = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned c0;
        logic [39:0] exp40;
        bit expo40;

        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        idle(2);

        // Single signed beat -3 * 7, latency NUM_STAGE+1.
        start_collect();
        drive(1, 1, 24'hFFFFFD, 16'd7, 1, 1, 1);
        c0 = ncyc;
        idle(8);
        collect = 1'b0;
        chk("single_count", 64'(obs.size()), 64'(1));
        if (obs.size() >= 1) begin
            chk("single_dout", 64'(obs[0].d), 64'(48'hFFFF_FFFF_FFEB));
            chk("single_latency", 64'(obs[0].n), 64'(c0 + NS + 2));
        end

        // Four unsigned max-value beats.
        start_collect();
        for (int i = 0; i < 4; i++) drive(1, 1, 24'hFFFFFF, 16'hFFFF, 0, i == 0, i == 3);
        idle(8);
        collect = 1'b0;
        chk("umax_count", 64'(obs.size()), 64'(1));
        if (obs.size() >= 1) begin
            chk("umax_dout", 64'(obs[0].d), 64'(48'h03FF_FBFC_0004));
            chk("umax_ovf", 64'(obs[0].o), 64'(0));
        end

        // ce toggling during a signed 3-beat group: 2*3 + 4*5 + (-1)*6 = 20.
        start_collect();
        drive(1, 1, 24'd2, 16'd3, 1, 1, 0);        drive(0, 1, 24'd2, 16'd3, 1, 1, 0);
        drive(1, 1, 24'd4, 16'd5, 1, 0, 0);        drive(0, 1, 24'd4, 16'd5, 1, 0, 0);
        drive(1, 1, 24'hFFFFFF, 16'd6, 1, 0, 1);   drive(0, 1, 24'hFFFFFF, 16'd6, 1, 0, 1);
        for (int i = 0; i < 14; i++) drive((i % 2) == 0, 0, '0, '0, 0, 0, 0);
        collect = 1'b0;
        chk("ce_toggle_count", 64'(obs.size()), 64'(2));
        if (obs.size() >= 2) begin
            chk("ce_toggle_dout0", 64'(obs[0].d), 64'(20));
            chk("ce_toggle_dout1", 64'(obs[1].d), 64'(20));
            chk("ce_toggle_adjacent", 64'(obs[1].n - obs[0].n), 64'(1));
        end

        // Reset after beat 2 of a 4-beat group, then a lone 5*5.
        start_collect();
        drive(1, 1, 24'd3, 16'd4, 0, 1, 0);
        drive(1, 1, 24'd5, 16'd6, 0, 0, 0);
        do_reset();
        idle(2);
        drive(1, 1, 24'd5, 16'd5, 0, 1, 1);
        idle(8);
        collect = 1'b0;
        chk("rst_group_count", 64'(obs.size()), 64'(1));
        if (obs.size() >= 1) chk("rst_group_dout", 64'(obs[0].d), 64'(25));

        // Back-to-back single-beat groups 1..8 squared.
        start_collect();
        for (int i = 1; i <= 8; i++) drive(1, 1, 24'(i), 16'(i), 0, 1, 1);
        idle(8);
        collect = 1'b0;
        chk("b2b_count", 64'(obs.size()), 64'(8));
        for (int j = 0; j < obs.size() && j < 8; j++) begin
            chk("b2b_dout", 64'(obs[j].d), 64'((j + 1) * (j + 1)));
            if (j > 0) chk("b2b_adjacent", 64'(obs[j].n - obs[j-1].n), 64'(1));
        end
        do_reset();
        idle(2);

        // 40 signed beats of 2^38 into a 40-bit accumulator.
        start_collect();
        for (int i = 0; i < 40; i++) drive(1, 1, 24'h800000, 16'h8000, 1, i == 0, i == 39);
        idle(8);
        collect = 1'b0;
`ifdef BBJ_MAC_SAT_EN
        exp40 = 40'h7F_FFFF_FFFF; expo40 = 1'b1;
`else
        exp40 = 40'h0; expo40 = 1'b0;
`endif
        chk("acc40_count", 64'(cnt40), 64'(1));
        chk("acc40_dout", 64'(d40), 64'(exp40));
        chk("acc40_ovf", 64'(o40), 64'(expo40));
        chk("acc48_dout", 64'(dout), 64'(48'h0A00_0000_0000));

        // Randomized traffic with ce gaps, bubbles and a mid-run reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                  24'($urandom), 16'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
